// File: rtl/modulo_scan_pkg.sv
// Shared types and constants for the modulo scan sequencer.
// Also provides the lowest-enabled-index helper that is used when a scan starts.
package modulo_scan_pkg;

  localparam int SEL_W    = 2;
  localparam int N_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // A scan started from idle begins at the lowest set mask bit.
  function automatic logic [SEL_W-1:0] lowest_idx(input logic [N_DIGITS-1:0] mask);
    logic [SEL_W-1:0] idx;
    idx = 2'd0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = SEL_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/modulo_next_digit.sv
// Combinational search for the next enabled digit, scanning upward from idx+1 modulo 4.
// The wrap output flags a result at or below the current index, which includes the single-digit case.
module modulo_next_digit
  import modulo_scan_pkg::*;
(
  input  logic [SEL_W-1:0]    i_idx,
  input  logic [N_DIGITS-1:0] i_mask,
  output logic [SEL_W-1:0]    o_next,
  output logic                o_wrap
);

  logic [SEL_W-1:0] w_cand;
  logic [SEL_W-1:0] w_next;
  logic             w_found;

  // First set mask bit in the order idx+1, idx+2, idx+3, idx.
  always_comb begin
    w_next  = i_idx;
    w_found = 1'b0;
    w_cand  = i_idx;
    for (int k = 1; k <= N_DIGITS; k++) begin
      w_cand = i_idx + SEL_W'(k);
      if (!w_found && i_mask[w_cand]) begin
        w_next  = w_cand;
        w_found = 1'b1;
      end else begin
        w_next  = w_next;
      end
    end
  end

  assign o_next = w_next;
  assign o_wrap = w_found && (w_next <= i_idx);

endmodule

// File: rtl/modulo_scan_sequencer.sv
// Time-multiplexed scan sequencer driving the select and enable inputs of a 1:4 demux.
// Define SCAN_BLANK_EN to insert BLANK_CYCLES of blanking before each digit visit.
module modulo_scan_sequencer
  import modulo_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                input_clk,
  input  logic                input_rst_n,
  input  logic                input_run,
  input  logic [N_DIGITS-1:0] input_digit_mask,
  output logic [SEL_W-1:0]    out_sel,
  output logic                out_e,
  output logic                out_wrap
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
`endif

  scan_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel;
  logic             r_e;
  logic             r_wrap;

  scan_state_t      w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic             w_e_nxt;
  logic             w_wrap_nxt;
  logic             w_active;
  logic [SEL_W-1:0] w_adv_sel;
  logic             w_adv_wrap;

  modulo_next_digit u_next (
    .i_idx  (r_sel),
    .i_mask (input_digit_mask),
    .o_next (w_adv_sel),
    .o_wrap (w_adv_wrap)
  );

  assign w_active = input_run && (input_digit_mask != 4'b0000);

  // Next-state and next-output logic; the counter counts down to zero and reloads on entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_e_nxt     = 1'b0;
    w_wrap_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_active) begin
          w_sel_nxt   = lowest_idx(input_digit_mask);
`ifdef SCAN_BLANK_EN
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = BLANK_LOAD;
`else
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = DWELL_LOAD;
          w_e_nxt     = 1'b1;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
`ifdef SCAN_BLANK_EN
      ST_BLANK: begin
        if (!w_active) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = DWELL_LOAD;
          w_e_nxt     = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
`endif
      ST_SHOW: begin
        if (!w_active) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if ((r_cnt == {CNT_W{1'b0}}) || !input_digit_mask[r_sel]) begin
          // Dwell over, or the shown digit was just disabled: move on.
          w_sel_nxt   = w_adv_sel;
          w_wrap_nxt  = w_adv_wrap;
`ifdef SCAN_BLANK_EN
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = BLANK_LOAD;
`else
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = DWELL_LOAD;
          w_e_nxt     = 1'b1;
`endif
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          w_e_nxt     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge input_clk) begin
    if (!input_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_sel   <= 2'd0;
      r_e     <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_e     <= w_e_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign out_sel  = r_sel;
  assign out_e    = r_e;
  assign out_wrap = r_wrap;

endmodule
